serial_adder: RTL
=================

Name: serial_adder

Overview:
- Multi-cycle adder that feeds operands into one narrow full-adder slice, processing BITS_PER_CYCLE bits per clock.
- The slice carry is fed back through a register between chunks.
- Sits in the PipelineCPU datapath as a low-area alternative to the ripple-carry ALU adder.
- Has a start/busy/done handshake, and the result is held stable until the next operation completes.

Parameters:
- WIDTH, 32, operand and result width in bits.
- BITS_PER_CYCLE, 1, bits summed per clock. Must divide WIDTH.
- N (localparam), WIDTH/BITS_PER_CYCLE, number of chunk cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- ci  input  1  carry in; sampled on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when s/co/ovf are updated.
- s  output  WIDTH  sum, registered.
- co  output  1  carry out of the MSB.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset_n is synchronous, active-low, and sampled on the rising edge of clk.
  - On reset: state=IDLE; busy, done, s, co, ovf and the internal count/shift/carry registers all =0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 latches a, b and ci into the shift registers, clears count, and goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge E1..EN adds the low BITS_PER_CYCLE bits of the A/B shift registers plus the carry register.
  - The chunk sum shifts into the top of the result shift register; A/B shift right by BITS_PER_CYCLE; the carry register takes the slice carry out.
  - The carry into the top bit of the last chunk is captured for ovf.
  - At EN: result shift register goes to s, final carry to co, ovf is computed, state goes to DONE.
- DONE: done=1 for exactly this one cycle; the next edge goes to IDLE.
- Latency:
  - done is high in the cycle after EN, i.e. N edges after the accepting edge.
  - Throughput is one operation per N+2 cycles.
- busy=1 exactly in RUN (N cycles).
- s/co/ovf change only at EN and hold between operations. Partial results are never visible.
- Handshake rules:
  - start is ignored in RUN and DONE; no queueing.
  - start held high continuously gives back-to-back operations, with the next accept in the IDLE cycle after DONE.
  - a/b/ci may change freely after the accepting edge.
- Arithmetic:
  - Modulo 2^WIDTH.
  - {co,s} = a+b+ci.
  - ovf = (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]).
- Reset mid-operation (reset_n=0 in RUN or DONE): IDLE and all outputs 0 after that edge; the in-flight result is discarded.
- BITS_PER_CYCLE=WIDTH is legal: N=1, busy for one cycle.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - sub=1 latches ~b and forces carry-in to 1, giving s=a-b; ci is ignored.
  - co=1 means no borrow.
  - ovf uses the effective (inverted) B.
- When undefined: port sub is absent and the block is add-only.

Decomposition:
- Shared package/header (serial_adder_pkg):
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH and BITS_PER_CYCLE constants.
- One sub-module: add_chunk, a combinational BITS_PER_CYCLE-bit ripple of the codebase's one-bit full-adder cell.
  - Outputs: chunk sum, chunk carry out, and carry into the chunk's top bit (used for ovf).
- FSM, counter and shift registers stay in serial_adder.

Test Plan (WIDTH=32, BITS_PER_CYCLE=1 unless noted):
- Carry ripple: a=0x00000001, b=0xFFFFFFFF, ci=0, start pulse at E0 -> done only at E0+32 cycle; s=0x00000000, co=1, ovf=0; busy high exactly 32 cycles.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, ci=1 -> s=0x80000001, co=0, ovf=1; then a=0x80000000, b=0x80000000 -> s=0, co=1, ovf=1.
- Start ignored while busy: accept a=5, b=7; pulse start again mid-RUN with a=100, b=100 -> single done, s=12; no second done.
- Reset mid-operation: reset_n=0 at cycle 10 of RUN -> next cycle state IDLE, busy=0, done=0, s=0, co=0, ovf=0; new start with a=3, b=4 -> s=7 after 32 cycles.
- Back-to-back and parameter sweep: start held high with BITS_PER_CYCLE=8, a=0x12345678, b=0x11111111 -> done every 6 cycles, s=0x23456789; repeat with BITS_PER_CYCLE=32 -> done every 3 cycles.
- SERIAL_ADDER_SUB_EN defined: sub=1, a=10, b=3 -> s=7, co=1; a=3, b=10 -> s=0xFFFFFFF9, co=0, ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and default sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth        = 32;
  localparam int unsigned DefaultBitsPerCycle = 1;

endpackage

// File: rtl/serial_adder_if.sv
// Handshake/operand bundle of the serial adder. Optional sub port under SERIAL_ADDER_SUB_EN.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, ci, sub, input busy, done, s, co, ovf);
  modport slave  (input start, a, b, ci, sub, output busy, done, s, co, ovf);
`else
  modport master (output start, a, b, ci, input busy, done, s, co, ovf);
  modport slave  (input start, a, b, ci, output busy, done, s, co, ovf);
`endif

endinterface

// File: rtl/serial_adder_add_chunk.sv
// Combinational BITS-wide ripple of one-bit full-adder cells; also exposes the
// carry into the top bit so the caller can form signed overflow.
module serial_adder_add_chunk #(
  parameter int unsigned BITS = 1
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  output logic [BITS-1:0] sum,
  output logic            co,
  output logic            c_top
);

  logic [BITS:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < BITS; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co    = c[BITS];
    c_top = c[BITS-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder summing BITS_PER_CYCLE bits per clock with a registered carry.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned BITS_PER_CYCLE = DefaultBitsPerCycle
) (
  input logic           clk,
  input logic           reset_n,
  serial_adder_if.slave bus
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e                    state_q;
  logic                      busy_q, done_q, co_q, ovf_q, carry_q;
  logic [WIDTH-1:0]          a_q, b_q, res_q, s_q;
  logic [CntW-1:0]           cnt_q;
  logic [WIDTH-1:0]          b_eff, res_next;
  logic                      ci_eff;
  logic [BITS_PER_CYCLE-1:0] chunk_sum;
  logic                      chunk_co, chunk_ctop;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; ci is ignored while sub is set.
  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign ci_eff = bus.sub | bus.ci;
`else
  assign b_eff  = bus.b;
  assign ci_eff = bus.ci;
`endif

  serial_adder_add_chunk #(
    .BITS (BITS_PER_CYCLE)
  ) u_add_chunk (
    .a     (a_q[BITS_PER_CYCLE-1:0]),
    .b     (b_q[BITS_PER_CYCLE-1:0]),
    .ci    (carry_q),
    .sum   (chunk_sum),
    .co    (chunk_co),
    .c_top (chunk_ctop)
  );

  // New chunk enters at the top; after N shifts the result is LSB-aligned.
  always_comb begin
    res_next = res_q >> BITS_PER_CYCLE;
    res_next[WIDTH-1 -: BITS_PER_CYCLE] = chunk_sum;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= b_eff;
            carry_q <= ci_eff;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> BITS_PER_CYCLE;
          b_q     <= b_q >> BITS_PER_CYCLE;
          carry_q <= chunk_co;
          res_q   <= res_next;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            s_q     <= res_next;
            co_q    <= chunk_co;
            ovf_q   <= chunk_ctop ^ chunk_co;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;

endmodule
